// File: rtl/mxn_shift_sequencer_pkg.sv
// Shared FSM encoding, shift-control field positions and lane-index sizing
// for the shift sequencer and its testbench.
package mxn_shift_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int AMT_LO  = 1;
  localparam int DIR_BIT = 0;

  function automatic int fill_bit(input int width);
    return width - 1;
  endfunction

  function automatic int amt_hi(input int width);
    return width - 2;
  endfunction

  function automatic int lane_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

endpackage

// File: rtl/mxn_shift_sequencer_if.sv
// Command, result and shifter-facing bundle; the sequencer takes the slave side,
// the environment that feeds commands and models the shifter takes the master side.
interface mxn_shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) ();
  localparam int LANE_W = mxn_shift_pkg::lane_w(SETS);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [WIDTH-1:0]        cmd_data;
  logic [WIDTH-1:0]        cmd_shift;
  logic                    cmd_flush;
  logic [SETS*WIDTH-1:0]   in_packed;
  logic [SETS*WIDTH-1:0]   shift_packed;
  logic [SETS*WIDTH-1:0]   out_packed;
  logic [SETS*WIDTH-1:0]   overflow_packed;
  logic                    res_valid;
  logic                    res_ready;
  logic [WIDTH-1:0]        res_data;
  logic [WIDTH-1:0]        res_overflow;
  logic [LANE_W-1:0]       res_lane;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_data, cmd_shift, cmd_flush,
    input  out_packed, overflow_packed, res_ready,
    output cmd_ready, in_packed, shift_packed,
    output res_valid, res_data, res_overflow, res_lane, busy
  );

  modport master (
    output cmd_valid, cmd_data, cmd_shift, cmd_flush,
    output out_packed, overflow_packed, res_ready,
    input  cmd_ready, in_packed, shift_packed,
    input  res_valid, res_data, res_overflow, res_lane, busy
  );

endinterface

// File: rtl/mxn_shift_sequencer_lane_regfile.sv
// SETS x WIDTH lane registers: indexed single-lane write, whole-vector load,
// synchronous clear (clear wins), packed read-out with lane i at [i*WIDTH +: WIDTH].
module mxn_lane_regfile #(
  parameter int WIDTH  = 4,
  parameter int SETS   = 2,
  parameter int LANE_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [LANE_W-1:0]     widx,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  ld_all,
  input  logic [SETS*WIDTH-1:0] ld_packed,
  output logic [SETS*WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < SETS; i++) mem[i] <= '0;
    end else if (ld_all) begin
      for (int i = 0; i < SETS; i++) mem[i] <= ld_packed[i*WIDTH +: WIDTH];
    end else if (we && (int'(widx) < SETS)) begin
      mem[widx] <= wdata;
    end
  end

  for (genvar g = 0; g < SETS; g++) begin : g_pack
    assign q[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/mxn_shift_sequencer.sv
// Batches serial lane commands for the combinational shifter, captures its result one
// cycle after the batch closes, then drains lanes serially; res_* hold while res_ready=0.
module mxn_shift_sequencer
  import mxn_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mxn_shift_sequencer_if.slave bus
);

  localparam int LANE_W = lane_w(SETS);
  localparam int CNT_W  = $clog2(SETS + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt, n, idx;
  logic                  cmd_fire, res_fire, close_batch, drain_done;
  logic                  in_load, in_capture, in_drain;
  logic [SETS*WIDTH-1:0] opnd_q, ctrl_q, res_q, ovf_q;

  assign in_load    = (state == LOAD);
  assign in_capture = (state == CAPTURE);
  assign in_drain   = (state == DRAIN);

  assign cmd_fire = in_load && bus.cmd_valid;
  assign res_fire = in_drain && bus.res_ready;

  // A standalone flush only closes a non-empty batch; a flushing word is part of its batch.
  assign close_batch = in_load &&
                       (cmd_fire ? ((cnt == CNT_W'(SETS - 1)) || bus.cmd_flush)
                                 : (bus.cmd_flush && (cnt != '0)));
  assign drain_done  = res_fire && ((idx + CNT_W'(1)) == n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (close_batch) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.cmd_ready = in_load;
    bus.res_valid = in_drain;
    bus.busy      = !(in_load && (cnt == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      n   <= '0;
      idx <= '0;
    end else begin
      if (cmd_fire)   cnt <= cnt + CNT_W'(1);
      if (in_capture) n   <= cnt;
      if (res_fire)   idx <= idx + CNT_W'(1);
      if (drain_done) begin
        cnt <= '0;
        idx <= '0;
      end
    end
  end

  mxn_lane_regfile #(.WIDTH(WIDTH), .SETS(SETS), .LANE_W(LANE_W)) u_opnd (
    .clk(clk), .rst(rst), .clr(drain_done), .we(cmd_fire),
    .widx(cnt[LANE_W-1:0]), .wdata(bus.cmd_data),
    .ld_all(1'b0), .ld_packed('0), .q(opnd_q)
  );

  mxn_lane_regfile #(.WIDTH(WIDTH), .SETS(SETS), .LANE_W(LANE_W)) u_ctrl (
    .clk(clk), .rst(rst), .clr(drain_done), .we(cmd_fire),
    .widx(cnt[LANE_W-1:0]), .wdata(bus.cmd_shift),
    .ld_all(1'b0), .ld_packed('0), .q(ctrl_q)
  );

  mxn_lane_regfile #(.WIDTH(WIDTH), .SETS(SETS), .LANE_W(LANE_W)) u_res (
    .clk(clk), .rst(rst), .clr(drain_done), .we(1'b0),
    .widx('0), .wdata('0),
    .ld_all(in_capture), .ld_packed(bus.out_packed), .q(res_q)
  );

  mxn_lane_regfile #(.WIDTH(WIDTH), .SETS(SETS), .LANE_W(LANE_W)) u_ovf (
    .clk(clk), .rst(rst), .clr(drain_done), .we(1'b0),
    .widx('0), .wdata('0),
    .ld_all(in_capture), .ld_packed(bus.overflow_packed), .q(ovf_q)
  );

  assign bus.in_packed    = opnd_q;
  assign bus.shift_packed = ctrl_q;
  assign bus.res_data     = res_q[int'(idx) * WIDTH +: WIDTH];
  assign bus.res_overflow = ovf_q[int'(idx) * WIDTH +: WIDTH];
  assign bus.res_lane     = idx[LANE_W-1:0];

endmodule

// File: tb/tb_mxn_shift_sequencer.sv
// Directed scenarios plus randomized batches against a lane-level reference of the
// batch/drain behaviour; the shifter is either a fixed stub or a behavioural shifter.
module tb_mxn_shift_sequencer;
  import mxn_shift_pkg::*;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int FB = fill_bit(W);
  localparam int AH = amt_hi(W);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mxn_shift_sequencer_if #(.WIDTH(W), .SETS(S)) bus ();

  mxn_shift_sequencer #(.WIDTH(W), .SETS(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit model_mode = 1'b0;

  // Behavioural shifter: returns {overflow, out}; shifted-out bits collect in overflow.
  function automatic logic [2*W-1:0] shift_ref(input logic [W-1:0] d, input logic [W-1:0] c);
    logic [W-1:0] o, v;
    o = d;
    v = '0;
    for (int k = 0; k < int'(c[AH:AMT_LO]); k++) begin
      if (c[DIR_BIT] == 1'b0) begin
        v = {v[W-2:0], o[W-1]};
        o = {o[W-2:0], c[FB]};
      end else begin
        v = {o[0], v[W-1:1]};
        o = {c[FB], o[W-1:1]};
      end
    end
    return {v, o};
  endfunction

  always_comb begin
    logic [2*W-1:0] r;
    r = '0;
    bus.out_packed      = 8'hA5;
    bus.overflow_packed = 8'h0F;
    if (model_mode) begin
      for (int i = 0; i < S; i++) begin
        r = shift_ref(bus.in_packed[i*W +: W], bus.shift_packed[i*W +: W]);
        bus.out_packed[i*W +: W]      = r[W-1:0];
        bus.overflow_packed[i*W +: W] = r[2*W-1:W];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] s, input bit f);
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_shift = s;
    bus.cmd_flush = f;
    while (!bus.cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_flush = 1'b0;
  endtask

  task automatic solo_flush();
    bus.cmd_flush = 1'b1;
    step();
    bus.cmd_flush = 1'b0;
  endtask

  task automatic recv(input int lane, input logic [W-1:0] d, input logic [W-1:0] o, input int stall);
    int guard;
    guard = 0;
    while (!bus.res_valid && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("res_valid_timeout", 32'(bus.res_valid), 32'd1);
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", 32'(bus.res_valid), 32'd1);
      check("stall_lane", 32'(bus.res_lane), 32'(lane));
      check("stall_data", 32'(bus.res_data), 32'(d));
      step();
    end
    check("res_lane", 32'(bus.res_lane), 32'(lane));
    check("res_data", 32'(bus.res_data), 32'(d));
    check("res_ovf", 32'(bus.res_overflow), 32'(o));
    check("cmd_ready_in_drain", 32'(bus.cmd_ready), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic full_batch();
    send(4'h3, 4'h2, 1'b0);
    check("s1_ready_mid", 32'(bus.cmd_ready), 32'd1);
    check("s1_busy_mid", 32'(bus.busy), 32'd1);
    send(4'h9, 4'h3, 1'b0);
    check("s1_ready_cap", 32'(bus.cmd_ready), 32'd0);
    check("s1_valid_cap", 32'(bus.res_valid), 32'd0);
    check("s1_in_packed", 32'(bus.in_packed), 32'h93);
    check("s1_shift_packed", 32'(bus.shift_packed), 32'h32);
    recv(0, 4'h5, 4'hF, 0);
    recv(1, 4'hA, 4'h0, 0);
    check("s1_ready_back", 32'(bus.cmd_ready), 32'd1);
    check("s1_valid_back", 32'(bus.res_valid), 32'd0);
    check("s1_in_cleared", 32'(bus.in_packed), 32'h0);
    check("s1_busy_back", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   rd [S];
    logic [W-1:0]   rs [S];
    logic [2*W-1:0] er;
    logic [S*W-1:0] exp_in, exp_sh, cap_out, cap_ovf;
    int             k;

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_shift = '0;
    bus.cmd_flush = 1'b0;
    bus.res_ready = 1'b0;
    step();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_ovf", 32'(bus.res_overflow), 32'd0);
    check("rst_res_lane", 32'(bus.res_lane), 32'd0);
    check("rst_in_packed", 32'(bus.in_packed), 32'd0);
    check("rst_shift_packed", 32'(bus.shift_packed), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    step();
    rst = 1'b0;
    step();

    full_batch();

    // Early flush with the word
    send(4'h7, 4'h3, 1'b1);
    check("s2_in_packed", 32'(bus.in_packed), 32'h07);
    check("s2_shift_packed", 32'(bus.shift_packed), 32'h03);
    recv(0, 4'h5, 4'hF, 0);
    check("s2_single_done_ready", 32'(bus.cmd_ready), 32'd1);
    check("s2_single_done_valid", 32'(bus.res_valid), 32'd0);

    // Backpressure
    send(4'h1, 4'h0, 1'b1);
    recv(0, 4'h5, 4'hF, 5);
    check("s3_done_valid", 32'(bus.res_valid), 32'd0);

    // Standalone flush on empty batch
    solo_flush();
    check("s4_busy", 32'(bus.busy), 32'd0);
    check("s4_valid", 32'(bus.res_valid), 32'd0);
    check("s4_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    check("s4_valid_later", 32'(bus.res_valid), 32'd0);

    // Standalone flush closing a one-lane batch
    send(4'hC, 4'h5, 1'b0);
    solo_flush();
    check("sf_ready_cap", 32'(bus.cmd_ready), 32'd0);
    check("sf_in_packed", 32'(bus.in_packed), 32'h0C);
    recv(0, 4'h5, 4'hF, 0);
    check("sf_done_valid", 32'(bus.res_valid), 32'd0);

    // Reset mid-drain
    send(4'h3, 4'h2, 1'b0);
    send(4'h9, 4'h3, 1'b0);
    recv(0, 4'h5, 4'hF, 0);
    rst = 1'b1;
    #1;
    check("s5_ready", 32'(bus.cmd_ready), 32'd1);
    check("s5_valid", 32'(bus.res_valid), 32'd0);
    check("s5_in_packed", 32'(bus.in_packed), 32'd0);
    check("s5_shift_packed", 32'(bus.shift_packed), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("s5_busy_after", 32'(bus.busy), 32'd0);
    full_batch();

    // Behavioural shifter on both lanes
    model_mode = 1'b1;
    send(4'h3, 4'h2, 1'b0);
    send(4'h3, 4'h2, 1'b0);
    cap_out = bus.out_packed;
    cap_ovf = bus.overflow_packed;
    check("s6_cap_lane0", 32'(cap_out[W-1:0]), 32'h6);
    check("s6_cap_lane1", 32'(cap_out[2*W-1:W]), 32'h6);
    recv(0, cap_out[W-1:0], cap_ovf[W-1:0], 0);
    recv(1, cap_out[2*W-1:W], cap_ovf[2*W-1:W], 0);

    // Randomized batches against the lane-level reference
    for (int b = 0; b < 40; b++) begin
      k = int'($urandom_range(1, S));
      exp_in = '0;
      exp_sh = '0;
      for (int i = 0; i < k; i++) begin
        rd[i] = W'($urandom);
        rs[i] = W'($urandom);
        exp_in[i*W +: W] = rd[i];
        exp_sh[i*W +: W] = rs[i];
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        if (i == k - 1 && k < S) begin
          if ($urandom_range(0, 1) == 1) begin
            send(rd[i], rs[i], 1'b1);
          end else begin
            send(rd[i], rs[i], 1'b0);
            solo_flush();
          end
        end else begin
          send(rd[i], rs[i], 1'(($urandom_range(0, 3) == 0) && (i == k - 1)));
        end
      end
      check("rnd_ready_cap", 32'(bus.cmd_ready), 32'd0);
      check("rnd_in_packed", 32'(bus.in_packed), 32'(exp_in));
      check("rnd_shift_packed", 32'(bus.shift_packed), 32'(exp_sh));
      for (int i = 0; i < k; i++) begin
        er = shift_ref(rd[i], rs[i]);
        recv(i, er[W-1:0], er[2*W-1:W], int'($urandom_range(0, 2)));
      end
      check("rnd_done_valid", 32'(bus.res_valid), 32'd0);
      check("rnd_done_busy", 32'(bus.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
